idma_inoc_wr_ibuffer: RTL
=========================

Name: idma_inoc_wr_ibuffer

Overview:
Write-side counterpart of the ibuffer read engine. It accepts a 32-bit word stream from the iNoC receive path and packs the words into DATA_WIDTH-wide ibuffer lines. Each line is written with a per-byte strobe, starting at an arbitrary word address, which may be unaligned. It sits between the NoC receive/depacketiser and the ibuffer SRAM write port.

Parameters:
DATA_WIDTH, 128, ibuffer line width in bits
MEM_AW, 15, ibuffer line address width
STRB_WIDTH, DATA_WIDTH/8, byte strobe width
WORD_WIDTH, 32, stream word width
WORD_NUM, DATA_WIDTH/WORD_WIDTH, words per line (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ibuffer_wr_start  in  1  one-cycle start pulse; ignored while busy
ibuffer_word_addr  in  MEM_AW+$clog2(WORD_NUM)  start word address
ibuffer_word_num  in  13  number of words to write
wr_busy  out  1  transfer in progress
wr_done  out  1  one-cycle pulse when the final line write handshakes
recv_valid  in  1  stream word valid
recv_ready  out  1  stream word accepted when recv_valid && recv_ready
recv_data  in  WORD_WIDTH  stream word
recv_last  in  1  sender marks final word
ibuffer_cen  out  1  write request
ibuffer_wen  out  1  write enable; constant 1
ibuffer_ready  in  1  SRAM accepts request when ibuffer_cen && ibuffer_ready
ibuffer_addr  out  MEM_AW  line address
ibuffer_wdata  out  DATA_WIDTH  line data
ibuffer_wstrb  out  STRB_WIDTH  byte strobe
wr_err  out  1  sticky last-mismatch flag; present only with the macro

Behaviour:
- Reset values: wr_busy=0, wr_done=0, recv_ready=0, ibuffer_cen=0, ibuffer_addr=0, ibuffer_wdata=0, ibuffer_wstrb=0, wr_err=0. Reset mid-transfer aborts the transfer; all counters, the pack register and the mask are cleared.
- FSM states:
  - IDLE: on start with word_num!=0, go to RUN. Latch line addr = word_addr>>log2(WORD_NUM), word_offset = word_addr[log2(WORD_NUM)-1:0], and the word count.
  - IDLE, start with word_num==0: no writes; wr_done pulses the next cycle; stay IDLE.
  - RUN: accept words.
  - DRAIN: all words accepted; wait for the final line handshake; then go to IDLE.
- wr_busy = (state!=IDLE).
- recv_ready = (state==RUN) && !(ibuffer_cen && !ibuffer_ready). The single output write register must be free or handshaking this cycle.
- On word accept:
  - write recv_data into pack slot word_offset and set mask bit word_offset;
  - word_offset increments and wraps modulo WORD_NUM;
  - word counter increments.
- A line is issued when either condition holds on an accepted word:
  - word_offset==WORD_NUM-1, or
  - the word is the final one (counter==word_num-1).
- Issuing a line:
  - the pack data and mask load into the output register next cycle;
  - ibuffer_wstrb = mask, each bit expanded to 4 bytes;
  - ibuffer_cen=1 with latency 1 cycle from the completing accept;
  - pack register and mask clear.
- ibuffer_addr increments by 1 after each write handshake and wraps at 2^MEM_AW.
- ibuffer_cen holds, with data, addr and strobe stable, while ibuffer_ready=0. It drops the cycle after the handshake unless a new line was issued in the handshake cycle; back-to-back writes are allowed.
- Completion is counter-based; recv_last does not terminate the transfer. The final accepted word moves RUN to DRAIN. wr_done pulses on the handshake of the final line; the FSM enters IDLE the same edge.
- Start pulses while busy are ignored.
- Line count = ((word_addr+word_num-1)>>log2(WORD_NUM)) - (word_addr>>log2(WORD_NUM)) + 1.

Optional Feature:
- Macro: IDMA_INOC_WR_LAST_CHK_EN.
- When defined:
  - wr_err port exists;
  - wr_err sets when an accepted word has recv_last != (counter==word_num-1);
  - it stays set until reset or the next accepted start;
  - data flow is unaffected.
- When undefined: wr_err is absent, recv_last is ignored, and no checker logic exists.

Test Plan:
- addr=0x10, num=8, ready always 1, continuous valid -> two writes, addr 0x4 and 0x5, wstrb=0xFFFF; cen first high 1 cycle after word 3 is accepted; wr_done pulses on the second handshake.
- addr=0x13, num=3 -> line 0x4, wstrb=0xF000; then line 0x5, wstrb=0x00FF, with word slots 0,1 holding words 1,2.
- addr=0x20, num=4, ibuffer_ready low 5 cycles -> cen/addr/wdata held; recv_ready=0 while stalled once the next line is pending; no word lost.
- num=0 start -> no cen; wr_done pulses the cycle after start; wr_busy stays 0.
- rst_n asserted mid-transfer after 2 of 8 words -> all outputs at reset values immediately; a fresh start of addr=0, num=4 completes normally with one write, wstrb=0xFFFF.
- With IDMA_INOC_WR_LAST_CHK_EN: num=4, recv_last on word 2 -> wr_err=1 after that accept; writes identical to the no-error case.

Source files
------------

// File: rtl/idma_inoc_wr_ibuffer_if.sv
// Stream-in / ibuffer-write port bundle for idma_inoc_wr_ibuffer.
// master = write engine side, slave = NoC receiver plus SRAM side.
interface idma_inoc_wr_ibuffer_if #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MEM_AW     = 15,
  parameter int unsigned WORD_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  recv_valid;
  logic                  recv_ready;
  logic [WORD_WIDTH-1:0] recv_data;
  logic                  recv_last;

  logic                  ibuffer_cen;
  logic                  ibuffer_wen;
  logic                  ibuffer_ready;
  logic [MEM_AW-1:0]     ibuffer_addr;
  logic [DATA_WIDTH-1:0] ibuffer_wdata;
  logic [STRB_WIDTH-1:0] ibuffer_wstrb;

  modport master (
    input  recv_valid, recv_data, recv_last, ibuffer_ready,
    output recv_ready, ibuffer_cen, ibuffer_wen, ibuffer_addr, ibuffer_wdata, ibuffer_wstrb
  );

  modport slave (
    output recv_valid, recv_data, recv_last, ibuffer_ready,
    input  recv_ready, ibuffer_cen, ibuffer_wen, ibuffer_addr, ibuffer_wdata, ibuffer_wstrb
  );
endinterface

// File: rtl/idma_inoc_wr_ibuffer.sv
// Packs a 32-bit iNoC receive stream into strobed ibuffer line writes from an unaligned word address.
// Optional recv_last consistency checker (wr_err) enabled by defining IDMA_INOC_WR_LAST_CHK_EN.
module idma_inoc_wr_ibuffer #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MEM_AW     = 15,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned WORD_NUM   = DATA_WIDTH / WORD_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ibuffer_wr_start,
  input  logic [MEM_AW+$clog2(WORD_NUM)-1:0]    ibuffer_word_addr,
  input  logic [12:0]                           ibuffer_word_num,
  output logic                                  wr_busy,
  output logic                                  wr_done,
`ifdef IDMA_INOC_WR_LAST_CHK_EN
  output logic                                  wr_err,
`endif
  idma_inoc_wr_ibuffer_if.master                bus
);

  localparam int unsigned OFF_W      = $clog2(WORD_NUM);
  localparam int unsigned WADDR_W    = MEM_AW + OFF_W;
  localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;
  localparam int unsigned CNT_W      = 13;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                                state_q, state_d;
  logic [OFF_W-1:0]                      off_q;
  logic [CNT_W-1:0]                      cnt_q;
  logic [CNT_W-1:0]                      num_q;
  logic [WORD_NUM-1:0][WORD_WIDTH-1:0]   pack_q;
  logic [WORD_NUM-1:0]                   mask_q;
  logic                                  cen_q;
  logic [MEM_AW-1:0]                     addr_q;
  logic [DATA_WIDTH-1:0]                 wdata_q;
  logic [STRB_WIDTH-1:0]                 wstrb_q;

  logic                                  start_c;
  logic                                  hs_c;
  logic                                  recv_ready_c;
  logic                                  acc_c;
  logic                                  last_word_c;
  logic                                  issue_c;
  logic [WORD_NUM-1:0][WORD_WIDTH-1:0]   pack_mrg_c;
  logic [WORD_NUM-1:0]                   mask_mrg_c;
  logic [STRB_WIDTH-1:0]                 strb_mrg_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_c && (ibuffer_word_num != '0)) state_d = RUN;
      RUN:     if (acc_c && last_word_c)                state_d = DRAIN;
      DRAIN:   if (hs_c)                                state_d = IDLE;
      default:                                          state_d = IDLE;
    endcase
  end

  // Handshake decode and the pack/mask view including the word accepted this cycle
  always_comb begin
    start_c      = ibuffer_wr_start && (state_q == IDLE);
    hs_c         = cen_q && bus.ibuffer_ready;
    recv_ready_c = (state_q == RUN) && !(cen_q && !bus.ibuffer_ready);
    acc_c        = bus.recv_valid && recv_ready_c;
    last_word_c  = (cnt_q == (num_q - CNT_W'(1)));
    issue_c      = acc_c && ((off_q == OFF_W'(WORD_NUM - 1)) || last_word_c);
    pack_mrg_c          = pack_q;
    pack_mrg_c[off_q]   = bus.recv_data;
    mask_mrg_c          = mask_q | (WORD_NUM'(1) << off_q);
    strb_mrg_c          = '0;
    for (int i = 0; i < WORD_NUM; i++) begin
      strb_mrg_c[i*WORD_BYTES +: WORD_BYTES] = {WORD_BYTES{mask_mrg_c[i]}};
    end
  end

  // Word packing and transfer bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      cnt_q  <= '0;
      num_q  <= '0;
      pack_q <= '0;
      mask_q <= '0;
    end else if (start_c && (ibuffer_word_num != '0)) begin
      off_q  <= ibuffer_word_addr[OFF_W-1:0];
      cnt_q  <= '0;
      num_q  <= ibuffer_word_num;
      pack_q <= '0;
      mask_q <= '0;
    end else if (acc_c) begin
      off_q <= off_q + OFF_W'(1);
      cnt_q <= cnt_q + CNT_W'(1);
      if (issue_c) begin
        pack_q <= '0;
        mask_q <= '0;
      end else begin
        pack_q <= pack_mrg_c;
        mask_q <= mask_mrg_c;
      end
    end
  end

  // Single write register: load on issue, hold while stalled, drop after handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (issue_c) begin
      cen_q   <= 1'b1;
      wdata_q <= pack_mrg_c;
      wstrb_q <= strb_mrg_c;
    end else if (hs_c) begin
      cen_q   <= 1'b0;
    end
  end

  // Line address: latched at start, advanced by every write handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (start_c && (ibuffer_word_num != '0)) begin
      addr_q <= ibuffer_word_addr[WADDR_W-1:OFF_W];
    end else if (hs_c) begin
      addr_q <= addr_q + MEM_AW'(1);
    end
  end

  // Status outputs; a zero-length start completes immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_busy <= 1'b0;
      wr_done <= 1'b0;
    end else begin
      wr_busy <= (state_d != IDLE);
      wr_done <= (start_c && (ibuffer_word_num == '0)) || ((state_q == DRAIN) && hs_c);
    end
  end

`ifdef IDMA_INOC_WR_LAST_CHK_EN
  // Sticky flag: sender's last marker disagrees with the programmed word count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if (start_c) begin
      wr_err <= 1'b0;
    end else if (acc_c && (bus.recv_last != last_word_c)) begin
      wr_err <= 1'b1;
    end
  end
`else
  logic unused_recv_last;
  assign unused_recv_last = bus.recv_last;
`endif

  assign bus.recv_ready    = recv_ready_c;
  assign bus.ibuffer_cen   = cen_q;
  assign bus.ibuffer_wen   = 1'b1;
  assign bus.ibuffer_addr  = addr_q;
  assign bus.ibuffer_wdata = wdata_q;
  assign bus.ibuffer_wstrb = wstrb_q;

endmodule
